overcurrent_guard: RTL and testbench

Sits between the current sensor and the motor controller. It consumes raw 12-bit current samples and block-averages them. A fault FSM compares each average against trip and clear thresholds, then drives the motor enable that gates the H-bridge IN lines. It applies timed retry, and latches a lockout after repeated trips until the operator clears it.

---
 rtl/ocg_pkg.sv | 24 ++
 rtl/ocg_averager.sv | 57 +++++
 rtl/overcurrent_guard.sv | 162 ++++++++++++++++
 tb/tb_overcurrent_guard.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ocg_pkg
// Purpose  : Shared types and constants for the overcurrent guard.
// Revision : 1.0  initial release
// ============================================================================
package ocg_pkg;

  // Default sample / average width.
  localparam int DATA_W_DEF = 12;

  // trip_count width; a 3-bit counter saturates at 7.
  localparam int TRIP_CNT_W = 3;

  // Fault FSM states.
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_TRIP = 2'd1,
    ST_COOL = 2'd2,
    ST_LOCK = 2'd3
  } ocg_state_e;

endpackage : ocg_pkg
`default_nettype wire

// File: rtl/ocg_averager.sv
`default_nettype none
// ============================================================================
// Module   : ocg_averager
// Purpose  : Block averager. Sums 2^AVG_LOG2 valid samples and publishes the
//            truncated mean with a one-cycle valid strobe.
// Revision : 1.0  initial release
// ============================================================================
module ocg_averager
  import ocg_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int AVG_LOG2 = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic [DATA_W-1:0] avg_current,
  output logic              avg_valid
);

  // Wide enough to hold a full block of maximum samples.
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0]    r_acc;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [ACC_W-1:0]    w_sum;
  logic                w_last;

  // Running sum including the sample arriving this cycle.
  assign w_sum  = r_acc + {{AVG_LOG2{1'b0}}, sample};
  assign w_last = (r_cnt == '1);

  // Accumulate; on the last sample of a block publish the mean and restart at 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      avg_current <= '0;
      avg_valid   <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (sample_valid) begin
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          r_acc       <= '0;
          avg_current <= DATA_W'(w_sum >> AVG_LOG2);
          avg_valid   <= 1'b1;
        end else begin
          r_acc <= w_sum;
        end
      end
    end
  end

endmodule : ocg_averager
`default_nettype wire

// File: rtl/overcurrent_guard.sv
`default_nettype none
// ============================================================================
// Module   : overcurrent_guard
// Purpose  : Averages current-sensor samples and gates the motor enable with a
//            trip / cooldown / lockout fault FSM.
//            Optional macro OCG_PEAK_HOLD_EN adds a peak_current output.
// Revision : 1.0  initial release
// ============================================================================
module overcurrent_guard
  import ocg_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int AVG_LOG2    = 3,
  parameter int TRIP_LEVEL  = 3000,
  parameter int CLEAR_LEVEL = 2500,
  parameter int COOL_CYCLES = 100000000,
  parameter int MAX_TRIPS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     sample,
  input  logic                  sample_valid,
  input  logic                  clear_fault,
  output logic                  motor_en,
  output logic                  fault,
  output logic                  lockout,
  output logic [DATA_W-1:0]     avg_current,
  output logic                  avg_valid,
  output logic [TRIP_CNT_W-1:0] trip_count
`ifdef OCG_PEAK_HOLD_EN
  ,
  output logic [DATA_W-1:0]     peak_current
`endif
);

  localparam int                  CNT_W     = $clog2(COOL_CYCLES + 1);
  localparam logic [CNT_W-1:0]    COOL_LAST = CNT_W'(COOL_CYCLES - 1);
  localparam logic [DATA_W-1:0]   TRIP_LVL  = DATA_W'(TRIP_LEVEL);
  localparam logic [DATA_W-1:0]   CLEAR_LVL = DATA_W'(CLEAR_LEVEL);
  localparam logic [TRIP_CNT_W-1:0] MAX_T   = TRIP_CNT_W'(MAX_TRIPS);

  ocg_state_e       r_state;
  ocg_state_e       w_next;
  logic [CNT_W-1:0] r_quiet;
  logic [CNT_W-1:0] r_cool;
  logic             w_trip_hit;
  logic             w_motor_en_d;
  logic             w_fault_d;
  logic             w_lockout_d;

  ocg_averager #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_averager (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .avg_current  (avg_current),
    .avg_valid    (avg_valid)
  );

  // A fresh average at or above the trip level while running.
  assign w_trip_hit = (r_state == ST_RUN) && avg_valid && (avg_current >= TRIP_LVL);

  // State register plus registered outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      motor_en <= 1'b1;
      fault    <= 1'b0;
      lockout  <= 1'b0;
    end else begin
      r_state  <= w_next;
      motor_en <= w_motor_en_d;
      fault    <= w_fault_d;
      lockout  <= w_lockout_d;
    end
  end

  // Next-state selection.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_RUN:  if (w_trip_hit) w_next = ST_TRIP;
      ST_TRIP: w_next = (trip_count >= MAX_T) ? ST_LOCK : ST_COOL;
      ST_COOL: if ((r_cool == '0) && (avg_current < CLEAR_LVL)) w_next = ST_RUN;
      ST_LOCK: if (clear_fault) w_next = ST_RUN;
      default: w_next = ST_RUN;
    endcase
  end

  // Output decode of the state about to be entered.
  always_comb begin
    w_motor_en_d = (w_next == ST_RUN);
    w_fault_d    = (w_next == ST_TRIP) || (w_next == ST_COOL);
    w_lockout_d  = (w_next == ST_LOCK);
  end

  // Trip count, quiet-period counter and cooldown counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      trip_count <= '0;
      r_quiet    <= '0;
      r_cool     <= '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_trip_hit) begin
            // Trip beats a coinciding quiet expiry; count from the old value.
            trip_count <= (trip_count == '1) ? trip_count : trip_count + 1'b1;
            r_quiet    <= '0;
          end else if (r_quiet == COOL_LAST) begin
            trip_count <= '0;
            r_quiet    <= '0;
          end else begin
            r_quiet <= r_quiet + 1'b1;
          end
        end
        ST_TRIP: begin
          r_quiet <= '0;
          r_cool  <= COOL_LAST;
        end
        ST_COOL: begin
          r_quiet <= '0;
          if (r_cool == '0) begin
            r_cool <= COOL_LAST;
          end else begin
            r_cool <= r_cool - 1'b1;
          end
        end
        ST_LOCK: begin
          r_quiet <= '0;
          if (clear_fault) trip_count <= '0;
        end
        default: begin
          r_quiet <= '0;
        end
      endcase
    end
  end

`ifdef OCG_PEAK_HOLD_EN
  logic [DATA_W-1:0] r_peak;

  // Largest average since reset or the last operator re-arm.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_peak <= '0;
    end else if ((r_state == ST_LOCK) && clear_fault) begin
      r_peak <= '0;
    end else if (avg_valid && (avg_current > r_peak)) begin
      r_peak <= avg_current;
    end
  end

  // Show a new maximum in the same cycle its avg_valid strobe is high.
  assign peak_current = (avg_valid && (avg_current > r_peak)) ? avg_current : r_peak;
`endif

endmodule : overcurrent_guard
`default_nettype wire

// File: tb/tb_overcurrent_guard.sv
`default_nettype none
// ============================================================================
// Module   : tb_overcurrent_guard
// Purpose  : Self-checking bench for overcurrent_guard with a deadline-based
//            reference model updated at every clock edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_overcurrent_guard;

  localparam int C    = 20;
  localparam int MAXT = 3;
  localparam int TRIP = 3000;
  localparam int CLR  = 2500;

  localparam int MODE_RUN  = 0;
  localparam int MODE_TRIP = 1;
  localparam int MODE_COOL = 2;
  localparam int MODE_LOCK = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        clear_fault = 1'b0;
  logic        motor_en;
  logic        fault;
  logic        lockout;
  logic [11:0] avg_current;
  logic        avg_valid;
  logic [2:0]  trip_count;

  overcurrent_guard #(
    .DATA_W      (12),
    .AVG_LOG2    (3),
    .TRIP_LEVEL  (TRIP),
    .CLEAR_LEVEL (CLR),
    .COOL_CYCLES (C),
    .MAX_TRIPS   (MAXT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sample       (sample),
    .sample_valid (sample_valid),
    .clear_fault  (clear_fault),
    .motor_en     (motor_en),
    .fault        (fault),
    .lockout      (lockout),
    .avg_current  (avg_current),
    .avg_valid    (avg_valid),
    .trip_count   (trip_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference model: mode plus absolute cycle deadlines.
  bit m_init = 0;
  int m_mode, m_trips, quiet_dl, cool_dl, m_avg;
  bit m_avgv;
  int blk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int sum;
    if (!reset) begin
      m_init   = 1;
      m_mode   = MODE_RUN;
      m_trips  = 0;
      m_avg    = 0;
      m_avgv   = 0;
      quiet_dl = cyc + C;
      blk.delete();
    end else if (m_init) begin
      case (m_mode)
        MODE_RUN: begin
          if (m_avgv && m_avg >= TRIP) begin
            m_mode  = MODE_TRIP;
            m_trips = (m_trips < 7) ? m_trips + 1 : 7;
          end else if (cyc == quiet_dl) begin
            m_trips  = 0;
            quiet_dl = cyc + C;
          end
        end
        MODE_TRIP: begin
          if (m_trips >= MAXT) m_mode = MODE_LOCK;
          else begin
            m_mode  = MODE_COOL;
            cool_dl = cyc + C;
          end
        end
        MODE_COOL: begin
          if (cyc == cool_dl) begin
            if (m_avg < CLR) begin
              m_mode   = MODE_RUN;
              quiet_dl = cyc + C;
            end else begin
              cool_dl = cyc + C;
            end
          end
        end
        default: begin
          if (clear_fault) begin
            m_mode   = MODE_RUN;
            m_trips  = 0;
            quiet_dl = cyc + C;
          end
        end
      endcase
      m_avgv = 0;
      if (sample_valid) begin
        blk.push_back(int'(sample));
        if (blk.size() == 8) begin
          sum = 0;
          foreach (blk[i]) sum += blk[i];
          m_avg  = sum / 8;
          m_avgv = 1;
          blk.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    if (m_init) begin
      chk("motor_en",    32'(motor_en),    32'(m_mode == MODE_RUN));
      chk("fault",       32'(fault),       32'(m_mode == MODE_TRIP || m_mode == MODE_COOL));
      chk("lockout",     32'(lockout),     32'(m_mode == MODE_LOCK));
      chk("avg_current", 32'(avg_current), 32'(m_avg));
      chk("avg_valid",   32'(avg_valid),   32'(m_avgv));
      chk("trip_count",  32'(trip_count),  32'(m_trips));
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic feed(input int val, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      sample       = 12'(val);
      sample_valid = 1'b1;
      step();
      sample_valid = 1'b0;
      if (gaps) idle(int'($urandom_range(0, 2)));
    end
  endtask

  // what: 0 = wait for motor_en, 1 = wait for lockout
  task automatic wait_for(input int what, input int maxc, input string tag);
    int n = 0;
    while (!((what == 0) ? (motor_en === 1'b1) : (lockout === 1'b1)) && n < maxc) begin
      step();
      n++;
    end
    chk(tag, 32'((what == 0) ? motor_en : lockout), 32'd1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_motor_en"}, 32'(motor_en), 32'd1);
    chk({tag, "_fault"},    32'(fault),    32'd0);
    chk({tag, "_lockout"},  32'(lockout),  32'd0);
    chk({tag, "_avg"},      32'(avg_current), 32'd0);
    chk({tag, "_avgv"},     32'(avg_valid),   32'd0);
    chk({tag, "_trips"},    32'(trip_count),  32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    reset = 1'b0;
    idle(2);
    chk_reset_vals("rst");
    reset = 1'b1;

    // Normal averaging with irregular sample spacing
    feed(1000, 8, 1'b1);
    idle(2);
    chk("p1_avg", 32'(avg_current), 32'd1000);
    chk("p1_motor", 32'(motor_en), 32'd1);
    chk("p1_fault", 32'(fault), 32'd0);

    // Trip, cooldown, recovery
    feed(3000, 8, 1'b0);
    chk("p2_avgv", 32'(avg_valid), 32'd1);
    idle(2);
    chk("p2_motor_off", 32'(motor_en), 32'd0);
    chk("p2_trips", 32'(trip_count), 32'd1);
    feed(1000, 8, 1'b0);
    wait_for(0, 40, "p2_back_to_run");

    // Hysteresis: 2500 keeps COOL through a reload, 2499 releases it
    feed(3000, 8, 1'b0);
    idle(2);
    feed(2500, 8, 1'b0);
    idle(14);
    chk("p3_still_cool", 32'(fault), 32'd1);
    feed(2499, 8, 1'b0);
    wait_for(0, 40, "p3_back_to_run");

    // Third trip without a quiet period: lockout
    feed(3000, 8, 1'b0);
    wait_for(1, 10, "p4_lock");
    idle(5);
    chk("p4_lock_held", 32'(lockout), 32'd1);
    chk("p4_motor_off", 32'(motor_en), 32'd0);
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    chk("p4_rearm_motor", 32'(motor_en), 32'd1);
    chk("p4_rearm_trips", 32'(trip_count), 32'd0);
    clear_fault = 1'b1;
    step();
    clear_fault = 1'b0;
    step();
    chk("p4_clear_in_run", 32'(motor_en), 32'd1);

    // Quiet period clears the trip count
    feed(3000, 8, 1'b0);
    idle(2);
    feed(1000, 8, 1'b0);
    wait_for(0, 60, "p5_run_a");
    chk("p5_trips_one", 32'(trip_count), 32'd1);
    idle(20);
    chk("p5_quiet_clear", 32'(trip_count), 32'd0);

    // Trip landing on the quiet expiry edge
    feed(3000, 8, 1'b0);
    idle(2);
    feed(1000, 8, 1'b0);
    wait_for(0, 60, "p5_run_b");
    idle(11);
    feed(3000, 8, 1'b0);
    step();
    chk("p5_same_cycle_trips", 32'(trip_count), 32'd2);
    chk("p5_same_cycle_motor", 32'(motor_en), 32'd0);
    feed(1000, 8, 1'b0);
    wait_for(0, 60, "p5_run_c");

    // Reset while locked, then mid-block
    feed(3000, 8, 1'b0);
    wait_for(1, 10, "p6_lock");
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_reset_vals("p6_rst_lock");
    feed(1234, 5, 1'b0);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_reset_vals("p6_rst_mid");
    feed(800, 8, 1'b0);
    chk("p6_avg800", 32'(avg_current), 32'd800);
    chk("p6_avgv", 32'(avg_valid), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      sample_valid = ($urandom_range(0, 3) != 0);
      sample       = 12'($urandom_range(2000, 3600));
      clear_fault  = ($urandom_range(0, 15) == 0);
      reset        = ($urandom_range(0, 299) != 0);
      step();
    end
    sample_valid = 1'b0;
    clear_fault  = 1'b0;
    reset        = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_overcurrent_guard
`default_nettype wire
